// File: rtl/prgmem_arbiter_pkg.sv
// Shared definitions for the program-memory arbiter slice.
// Holds the default geometry of the program memory and the encoding of the
// response-owner register that tags each read grant.
package prgmem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 12;
  localparam int unsigned DEF_NB_COL     = 4;
  localparam int unsigned DEF_COL_WIDTH  = 8;
  localparam int unsigned DEF_MAX_LOCK   = 8;

  typedef logic [1:0] resp_sel_t;

  localparam resp_sel_t RESP_IDLE = 2'b00;
  localparam resp_sel_t RESP_A    = 2'b01;
  localparam resp_sel_t RESP_B    = 2'b10;

endpackage

// File: rtl/prgmem_arbiter_if.sv
// Bundle of every non-clock signal around the program-memory arbiter:
// port A (fetch, read-only), port B (data/loader, read + byte-masked write)
// and the memory-side drive/return.
//   slave  : arbiter view (requests and memory data in, grants/responses and
//            memory drive out)
//   master : system view (requesters and memory instance)
interface prgmem_arbiter_if
  import prgmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NB_COL     = DEF_NB_COL,
  parameter int unsigned COL_WIDTH  = DEF_COL_WIDTH
);
  localparam int unsigned DW = NB_COL * COL_WIDTH;

  logic                  a_req;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic                  a_gnt;
  logic                  a_rvalid;
  logic [DW-1:0]         a_rdata;

  logic                  b_req;
  logic                  b_we;
  logic [NB_COL-1:0]     b_be;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DW-1:0]         b_wdata;
  logic                  b_lock;
  logic                  b_gnt;
  logic                  b_rvalid;
  logic [DW-1:0]         b_rdata;

  logic [NB_COL-1:0]     mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DW-1:0]         mem_data_in;
  logic [DW-1:0]         mem_data_out;

  modport slave (
    input  a_req, a_addr, b_req, b_we, b_be, b_addr, b_wdata, b_lock,
           mem_data_out,
    output a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
           mem_write_enable, mem_address, mem_data_in
  );

  modport master (
    output a_req, a_addr, b_req, b_we, b_be, b_addr, b_wdata, b_lock,
           mem_data_out,
    input  a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata,
           mem_write_enable, mem_address, mem_data_in
  );

endinterface

// File: rtl/prgmem_arbiter_rr_arb2.sv
// Two-requester round-robin grant logic with a bounded lock for port B.
// Ports:
//   clock, reset_n  : system clock, synchronous active-low reset
//   a_req, b_req    : requests from port A and port B
//   b_lock          : B asks to keep priority (atomic sequence)
//   a_gnt, b_gnt    : combinational one-hot-or-zero grants
module prgmem_rr_arb2 #(
  parameter int unsigned MAX_LOCK = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic a_req,
  input  logic b_req,
  input  logic b_lock,
  output logic a_gnt,
  output logic b_gnt
);
  localparam int unsigned CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_MAX = CW'(MAX_LOCK);

  logic          prio_b;
  logic          last_was_b;
  logic [CW-1:0] lock_cnt;
  logic          lock_hold;

  always_comb begin
    lock_hold = b_lock && last_was_b && (lock_cnt < LOCK_MAX);
    b_gnt     = b_req && (!a_req || prio_b || lock_hold);
    a_gnt     = a_req && !b_gnt;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      prio_b     <= 1'b0;
      last_was_b <= 1'b0;
      lock_cnt   <= '0;
    end else begin
      if (a_gnt)      prio_b <= 1'b1;
      else if (b_gnt) prio_b <= 1'b0;
      last_was_b <= b_gnt;
      // Only grants won against a waiting A consume lock budget.
      if (a_gnt || !b_lock)
        lock_cnt <= '0;
      else if (b_gnt && a_req && (lock_cnt < LOCK_MAX))
        lock_cnt <= lock_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/prgmem_arbiter.sv
// Shares the single-port, byte-write-enable program memory between the
// instruction-fetch port A and the data/loader port B.
// Ports:
//   clock, reset_n : system clock, synchronous active-low reset
//   bus (slave)    : A/B request/grant/response signals and the memory drive
//                    (write_enable, address, data_in) plus memory data_out
// Read data returns two cycles after the grant: one cycle of memory latency,
// one cycle of output register.
module prgmem_arbiter
  import prgmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NB_COL     = DEF_NB_COL,
  parameter int unsigned COL_WIDTH  = DEF_COL_WIDTH,
  parameter int unsigned MAX_LOCK   = DEF_MAX_LOCK
) (
  input logic             clock,
  input logic             reset_n,
  prgmem_arbiter_if.slave bus
);
  localparam int unsigned DW = NB_COL * COL_WIDTH;

  logic                  grant_a;
  logic                  grant_b;
  logic [ADDR_WIDTH-1:0] addr_q;
  resp_sel_t             resp_sel;
  logic                  a_rvalid_q;
  logic                  b_rvalid_q;
  logic [DW-1:0]         a_rdata_q;
  logic [DW-1:0]         b_rdata_q;

  prgmem_rr_arb2 #(.MAX_LOCK(MAX_LOCK)) u_arb (
    .clock   (clock),
    .reset_n (reset_n),
    .a_req   (bus.a_req),
    .b_req   (bus.b_req),
    .b_lock  (bus.b_lock),
    .a_gnt   (grant_a),
    .b_gnt   (grant_b)
  );

  assign bus.a_gnt = grant_a;
  assign bus.b_gnt = grant_b;

  // Address holds its last value when idle so the memory sees no change.
  assign bus.mem_address      = grant_a ? bus.a_addr :
                                grant_b ? bus.b_addr : addr_q;
  assign bus.mem_write_enable = (grant_b && bus.b_we) ? bus.b_be : '0;
  assign bus.mem_data_in      = bus.b_wdata;

  assign bus.a_rvalid = a_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.b_rdata  = b_rdata_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr_q     <= '0;
      resp_sel   <= RESP_IDLE;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      addr_q <= bus.mem_address;
      if (grant_a)                   resp_sel <= RESP_A;
      else if (grant_b && !bus.b_we) resp_sel <= RESP_B;
      else                           resp_sel <= RESP_IDLE;
      a_rvalid_q <= (resp_sel == RESP_A);
      b_rvalid_q <= (resp_sel == RESP_B);
      if (resp_sel == RESP_A) a_rdata_q <= bus.mem_data_out;
      if (resp_sel == RESP_B) b_rdata_q <= bus.mem_data_out;
    end
  end

endmodule

// File: tb/tb_prgmem_arbiter.sv
// Directed bench for prgmem_arbiter with a behavioural program memory.
module tb_prgmem_arbiter;

  logic clock;
  logic reset_n;
  int unsigned vectors;
  int unsigned miscompares;
  logic [31:0] mem [4096];

  prgmem_arbiter_if #(.ADDR_WIDTH(12), .NB_COL(4), .COL_WIDTH(8)) bus ();

  prgmem_arbiter #(.ADDR_WIDTH(12), .NB_COL(4), .COL_WIDTH(8), .MAX_LOCK(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port memory: data_out registered, refreshed only when not writing.
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
    mem[32] = 32'h1122_3344;
    bus.mem_data_out = '0;
    forever begin
      @(posedge clock);
      if (bus.mem_write_enable == 4'b0000)
        bus.mem_data_out <= mem[bus.mem_address];
      else
        for (int c = 0; c < 4; c++)
          if (bus.mem_write_enable[c])
            mem[bus.mem_address][c*8 +: 8] <= bus.mem_data_in[c*8 +: 8];
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset_n = 1'b0;
    bus.a_req = 0; bus.a_addr = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_be = '0; bus.b_addr = '0;
    bus.b_wdata = '0; bus.b_lock = 0;
    cyc(); cyc();
    #3;
    chk("rst_a_rvalid", 32'(bus.a_rvalid), 32'd0);
    chk("rst_b_rvalid", 32'(bus.b_rvalid), 32'd0);
    chk("rst_a_rdata", bus.a_rdata, 32'd0);
    chk("rst_b_rdata", bus.b_rdata, 32'd0);
    chk("rst_mem_we", 32'(bus.mem_write_enable), 32'd0);

    // Reset while an A read is in flight
    cyc(); reset_n = 1; bus.a_req = 1; bus.a_addr = 12'h010;
    #3 chk("midrst_gnt", 32'(bus.a_gnt), 32'd1);
    cyc(); bus.a_req = 0; reset_n = 0;
    #3 chk("midrst_rvalid0", 32'(bus.a_rvalid), 32'd0);
    cyc(); reset_n = 1;
    #3 chk("midrst_rvalid1", 32'(bus.a_rvalid), 32'd0);
    chk("midrst_rdata1", bus.a_rdata, 32'd0);
    cyc();
    #3 chk("midrst_rvalid2", 32'(bus.a_rvalid), 32'd0);
    chk("midrst_rdata2", bus.a_rdata, 32'd0);

    // A-only burst at 0x000..0x003
    for (int j = 0; j < 6; j++) begin
      cyc();
      bus.a_req = (j < 4);
      bus.a_addr = 12'(j);
      #3;
      if (j < 4) chk("aonly_gnt", 32'(bus.a_gnt), 32'd1);
      if (j >= 2) begin
        chk("aonly_rvalid", 32'(bus.a_rvalid), 32'd1);
        chk("aonly_rdata", bus.a_rdata, 32'hC0DE_0000 | 32'(j - 2));
      end else begin
        chk("aonly_rvalid0", 32'(bus.a_rvalid), 32'd0);
      end
    end

    // B masked write then read-back
    cyc(); bus.b_req = 1; bus.b_we = 1; bus.b_be = 4'b0101;
    bus.b_addr = 12'h020; bus.b_wdata = 32'hDEAD_BEEF;
    #3 chk("bw_gnt", 32'(bus.b_gnt), 32'd1);
    chk("bw_mem_we", 32'(bus.mem_write_enable), 32'h5);
    chk("bw_mem_addr", 32'(bus.mem_address), 32'h20);
    chk("bw_mem_din", bus.mem_data_in, 32'hDEAD_BEEF);
    cyc(); bus.b_we = 0;
    #3 chk("br_gnt", 32'(bus.b_gnt), 32'd1);
    chk("br_mem_we", 32'(bus.mem_write_enable), 32'd0);
    chk("br_rvalid_early", 32'(bus.b_rvalid), 32'd0);
    cyc(); bus.b_req = 0;
    #3 chk("bw_no_rvalid", 32'(bus.b_rvalid), 32'd0);
    cyc();
    #3 chk("br_rvalid", 32'(bus.b_rvalid), 32'd1);
    chk("br_rdata", bus.b_rdata, 32'h11AD_33EF);
    cyc();
    #3 chk("br_rvalid_drop", 32'(bus.b_rvalid), 32'd0);
    chk("br_rdata_hold", bus.b_rdata, 32'h11AD_33EF);

    // Write with no byte enables: granted, no memory change
    cyc(); bus.b_req = 1; bus.b_we = 1; bus.b_be = 4'b0000;
    bus.b_addr = 12'h021; bus.b_wdata = 32'hFFFF_FFFF;
    #3 chk("be0_gnt", 32'(bus.b_gnt), 32'd1);
    chk("be0_mem_we", 32'(bus.mem_write_enable), 32'd0);
    cyc(); bus.b_req = 0; bus.b_we = 0;
    cyc();
    #3 chk("be0_no_rvalid", 32'(bus.b_rvalid), 32'd0);
    cyc(); bus.b_req = 1;
    cyc(); bus.b_req = 0;
    cyc();
    #3 chk("be0_rb_rvalid", 32'(bus.b_rvalid), 32'd1);
    chk("be0_rb_rdata", bus.b_rdata, 32'hC0DE_0021);

    // Contention without lock: A,B,A,B after reset
    cyc(); reset_n = 0;
    cyc(); reset_n = 1; bus.a_req = 1; bus.b_req = 1; bus.b_lock = 0;
    bus.a_addr = 12'h001; bus.b_addr = 12'h002;
    for (int k = 0; k < 6; k++) begin
      #3;
      chk("rr_a_gnt", 32'(bus.a_gnt), 32'(k % 2 == 0));
      chk("rr_b_gnt", 32'(bus.b_gnt), 32'(k % 2 == 1));
      cyc();
    end

    // Lock bound: A, then 8 B grants, then one A, repeat
    reset_n = 0; bus.a_req = 0; bus.b_req = 0;
    cyc(); reset_n = 1; bus.a_req = 1; bus.b_req = 1; bus.b_lock = 1;
    bus.a_addr = 12'h005; bus.b_addr = 12'h006;
    for (int k = 0; k < 20; k++) begin
      #3;
      chk("lock_a_gnt", 32'(bus.a_gnt), 32'(k % 9 == 0));
      chk("lock_b_gnt", 32'(bus.b_gnt), 32'(k % 9 != 0));
      cyc();
    end
    bus.a_req = 0; bus.b_req = 0; bus.b_lock = 0;
    cyc(); cyc();

    // Idle gap
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("idle_mem_we", 32'(bus.mem_write_enable), 32'd0);
      chk("idle_a_rvalid", 32'(bus.a_rvalid), 32'd0);
      chk("idle_b_rvalid", 32'(bus.b_rvalid), 32'd0);
      chk("idle_addr_hold", 32'(bus.mem_address), 32'h006);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
